jogo_sequencia_param: RTL and testbench

JOGO_SEQUENCIA_PARAM -- requirements
Module: jogo_sequencia_param

---
 rtl/jogo_sequencia_param.sv | 210 +++++++++++++++++++++
 tb/tb_jogo_sequencia_param.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jogo_sequencia_param.sv
// ---------------------------------------------------------------------------
// jogo_sequencia_param
//
// Sequence-memory game. A sequence of key patterns is loaded into a small
// memory while the game is idle. In round r the player must repeat the first
// r items of the sequence. A play is one rising edge of "any key pressed".
// The game ends in success (all L rounds done), error (wrong key) or timeout
// (no play within TIMEOUT_CICLOS cycles).
//
// Parameters
//   N_CHAVES       width of the key input and of each sequence item
//   MAX_RODADAS    sequence depth and longest allowed game
//   TIMEOUT_CICLOS cycles allowed per play
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   synchronous, active-low reset
//   iniciar    in   start / restart (accepted only when idle or finished)
//   rodadas    in   requested game length, sampled when iniciar is accepted
//   chaves     in   player keys
//   mem_we     in   sequence memory write enable (idle state only)
//   mem_addr   in   sequence memory write address
//   mem_dado   in   sequence memory write data
//   pronto     out  game over
//   acertou    out  game won
//   errou      out  wrong key played
//   timeout    out  play window expired
//   leds       out  last registered play
//   db_estado  out  FSM state code
//   db_rodada  out  current round, 1-based
//   db_jogada  out  play index within the current round
// ---------------------------------------------------------------------------
module jogo_sequencia_param #(
    parameter int N_CHAVES       = 4,
    parameter int MAX_RODADAS    = 16,
    parameter int TIMEOUT_CICLOS = 5000,
    localparam int A             = $clog2(MAX_RODADAS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic [A:0]          rodadas,
    input  logic [N_CHAVES-1:0] chaves,
    input  logic                mem_we,
    input  logic [A-1:0]        mem_addr,
    input  logic [N_CHAVES-1:0] mem_dado,
    output logic                pronto,
    output logic                acertou,
    output logic                errou,
    output logic                timeout,
    output logic [N_CHAVES-1:0] leds,
    output logic [3:0]          db_estado,
    output logic [A:0]          db_rodada,
    output logic [A:0]          db_jogada
);

    localparam int            DEPTH   = 1 << A;
    localparam int            TW      = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [A:0]    L_MAX   = (A + 1)'(MAX_RODADAS);
    localparam logic [A:0]    ONE     = (A + 1)'(1);

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARA       = 4'h1,
        INICIA_RODADA = 4'h2,
        ESPERA        = 4'h3,
        REGISTRA      = 4'h4,
        COMPARA       = 4'h5,
        PROX_JOGADA   = 4'h6,
        PROX_RODADA   = 4'h7,
        FIM_ACERTO    = 4'hA,
        FIM_ERRO      = 4'hE,
        FIM_TIMEOUT   = 4'hF
    } estado_t;

    estado_t             state_q, state_d;
    logic [A:0]          r_q, r_d;
    logic [A:0]          j_q, j_d;
    logic [A:0]          l_q, l_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [N_CHAVES-1:0] leds_q, leds_d;
    logic [N_CHAVES-1:0] chaves_prev_q;
    logic [N_CHAVES-1:0] mem_q [DEPTH];

    logic                jogada_det;
    logic [A:0]          l_clamp;
    logic                fim;

    // A play is the first cycle keys are non-zero after an all-zero cycle, so
    // keys still held from an earlier play never register twice.
    assign jogada_det = (chaves != '0) && (chaves_prev_q == '0);

    always_comb begin
        l_clamp = rodadas;
        if (rodadas == '0) begin
            l_clamp = ONE;
        end else if (rodadas > L_MAX) begin
            l_clamp = L_MAX;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        j_d     = j_q;
        l_d     = l_q;
        tmo_d   = tmo_q;
        leds_d  = leds_q;
        case (state_q)
            INICIAL, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                if (iniciar) begin
                    l_d     = l_clamp;
                    state_d = PREPARA;
                end
            end
            PREPARA: begin
                r_d     = ONE;
                j_d     = '0;
                tmo_d   = '0;
                leds_d  = '0;
                state_d = INICIA_RODADA;
            end
            INICIA_RODADA: begin
                j_d     = '0;
                tmo_d   = '0;
                state_d = ESPERA;
            end
            ESPERA: begin
                // Counter saturates; a play on the expiry cycle still wins.
                if (tmo_q != TMO_MAX) begin
                    tmo_d = tmo_q + 1'b1;
                end
                if (jogada_det) begin
                    state_d = REGISTRA;
                end else if (tmo_q == TMO_MAX) begin
                    state_d = FIM_TIMEOUT;
                end
            end
            REGISTRA: begin
                leds_d  = chaves;
                state_d = COMPARA;
            end
            COMPARA: begin
                if (leds_q != mem_q[j_q[A-1:0]]) begin
                    state_d = FIM_ERRO;
                end else if (j_q == (r_q - ONE)) begin
                    state_d = PROX_RODADA;
                end else begin
                    state_d = PROX_JOGADA;
                end
            end
            PROX_JOGADA: begin
                if (j_q < r_q) begin
                    j_d = j_q + ONE;
                end
                tmo_d   = '0;
                state_d = ESPERA;
            end
            PROX_RODADA: begin
                if (r_q >= l_q) begin
                    state_d = FIM_ACERTO;
                end else begin
                    r_d     = r_q + ONE;
                    state_d = INICIA_RODADA;
                end
            end
            default: state_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= INICIAL;
            r_q           <= '0;
            j_q           <= '0;
            l_q           <= '0;
            tmo_q         <= '0;
            leds_q        <= '0;
            chaves_prev_q <= '0;
        end else begin
            state_q       <= state_d;
            r_q           <= r_d;
            j_q           <= j_d;
            l_q           <= l_d;
            tmo_q         <= tmo_d;
            leds_q        <= leds_d;
            chaves_prev_q <= chaves;
        end
    end

    // Sequence memory has no reset so a loaded sequence survives a reset.
    always_ff @(posedge clock) begin
        if (state_q == INICIAL && mem_we) begin
            mem_q[mem_addr] <= mem_dado;
        end
    end

    assign fim       = (state_q == FIM_ACERTO) || (state_q == FIM_ERRO) ||
                       (state_q == FIM_TIMEOUT);
    assign pronto    = fim;
    assign acertou   = (state_q == FIM_ACERTO);
    assign errou     = (state_q == FIM_ERRO);
    assign timeout   = (state_q == FIM_TIMEOUT);
    assign leds      = leds_q;
    assign db_estado = state_q;
    assign db_rodada = r_q;
    assign db_jogada = j_q;

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// ---------------------------------------------------------------------------
// tb_jogo_sequencia_param
//
// Bench for jogo_sequencia_param with MAX_RODADAS=4, N_CHAVES=4,
// TIMEOUT_CICLOS=10 and the sequence 1,2,4,8 in memory. Whole games are
// described by a table of scenarios; the expected end-of-game outputs are
// pushed to exp_q when a game is started and popped when pronto rises.
// Hand-written sequences cover exact timeout timing, play on the expiry
// cycle, ignored iniciar/mem_we while playing, held keys and mid-game reset.
// ---------------------------------------------------------------------------
module tb_jogo_sequencia_param;

    localparam int NK = 4;
    localparam int MR = 4;
    localparam int TC = 10;
    localparam int A  = 2;
    localparam int W  = 18;

    logic          clock = 1'b0;
    logic          reset;
    logic          iniciar;
    logic [A:0]    rodadas;
    logic [NK-1:0] chaves;
    logic          mem_we;
    logic [A-1:0]  mem_addr;
    logic [NK-1:0] mem_dado;
    logic          pronto, acertou, errou, timeout;
    logic [NK-1:0] leds;
    logic [3:0]    db_estado;
    logic [A:0]    db_rodada, db_jogada;

    always #5 clock = ~clock;

    jogo_sequencia_param #(
        .N_CHAVES       (NK),
        .MAX_RODADAS    (MR),
        .TIMEOUT_CICLOS (TC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .rodadas   (rodadas),
        .chaves    (chaves),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_dado  (mem_dado),
        .pronto    (pronto),
        .acertou   (acertou),
        .errou     (errou),
        .timeout   (timeout),
        .leds      (leds),
        .db_estado (db_estado),
        .db_rodada (db_rodada),
        .db_jogada (db_jogada)
    );

    // kind: 0 = win, 1 = wrong key at (ev_r, ev_j), 2 = no play at (ev_r, ev_j)
    typedef struct {
        logic [A:0]    rodadas;
        int            kind;
        int            ev_r;
        int            ev_j;
        logic [NK-1:0] key;
    } scen_t;

    scen_t         vec [12];
    logic [W-1:0]  exp_q [$];
    logic [NK-1:0] seq [MR];
    int            n_checks = 0;
    int            n_pass   = 0;

    // ---------------- clock / reset helpers ----------------
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        iniciar = 1'b0;
        chaves  = '0;
        mem_we  = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    function automatic logic [W-1:0] out_word();
        return {db_estado, pronto, acertou, errou, timeout, leds, db_rodada, db_jogada};
    endfunction

    function automatic int clamp_len(input logic [A:0] r);
        if (r == 0) return 1;
        if (int'(r) > MR) return MR;
        return int'(r);
    endfunction

    // Expected outputs once the game of scenario s has ended.
    function automatic logic [W-1:0] model(input scen_t s);
        int            l;
        logic [3:0]    st;
        logic [3:0]    flags;
        logic [NK-1:0] lv;
        int            rod, jog;
        l = clamp_len(s.rodadas);
        if (s.kind == 0) begin
            st = 4'hA; flags = 4'b1100; lv = seq[l-1]; rod = l; jog = l - 1;
        end else if (s.kind == 1) begin
            st = 4'hE; flags = 4'b1010; lv = s.key; rod = s.ev_r; jog = s.ev_j;
        end else begin
            st = 4'hF; flags = 4'b1001; rod = s.ev_r; jog = s.ev_j;
            if (s.ev_j > 0) lv = seq[s.ev_j-1];
            else if (s.ev_r > 1) lv = seq[s.ev_r-2];
            else lv = '0;
        end
        return {st, flags, lv, 3'(rod), 3'(jog)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_state(input logic [3:0] s, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (db_estado == s) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL %s: state stuck at 0x%0h, waiting for 0x%0h", name, db_estado, s);
        end
    endtask

    task automatic wait_pronto(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (pronto) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL %s: pronto=0 after 200 cycles, required 1", name);
        end
    endtask

    task automatic start_game(input logic [A:0] r);
        rodadas = r;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
    endtask

    task automatic press(input logic [NK-1:0] k);
        chaves = k;
        repeat (3) tick();
        chaves = '0;
        tick();
    endtask

    task automatic play_game(input scen_t s, input string name);
        int l;
        bit ok;
        bit done;
        l = clamp_len(s.rodadas);
        exp_q.push_back(model(s));
        start_game(s.rodadas);
        done = 1'b0;
        for (int r = 1; r <= l && !done; r++) begin
            for (int j = 0; j < r && !done; j++) begin
                wait_state(4'h3, name, ok);
                if (!ok) done = 1'b1;
                else if (s.kind == 2 && r == s.ev_r && j == s.ev_j) done = 1'b1;
                else if (s.kind == 1 && r == s.ev_r && j == s.ev_j) begin
                    press(s.key);
                    done = 1'b1;
                end else press(seq[j]);
            end
        end
        wait_pronto(name, ok);
        check(name, out_word(), exp_q.pop_front());
        if (!ok) do_reset();
    endtask

    // ---------------- test ----------------
    initial begin
        bit ok;
        scen_t s;
        seq = '{4'd1, 4'd2, 4'd4, 4'd8};
        rodadas  = '0;
        mem_addr = '0;
        mem_dado = '0;
        do_reset();
        check("reset_outputs", 32'(out_word()), 32'd0);

        for (int i = 0; i < MR; i++) begin
            mem_we   = 1'b1;
            mem_addr = A'(i);
            mem_dado = seq[i];
            tick();
        end
        mem_we = 1'b0;

        vec[0] = '{3'd3, 0, 0, 0, 4'd0};
        vec[1] = '{3'd2, 1, 2, 1, 4'd8};
        vec[2] = '{3'd1, 2, 1, 0, 4'd0};
        vec[3] = '{3'd0, 0, 0, 0, 4'd0};
        vec[4] = '{3'd7, 0, 0, 0, 4'd0};
        vec[5] = '{3'd4, 2, 3, 2, 4'd0};
        vec[6] = '{3'd4, 1, 4, 3, 4'd4};
        vec[7] = '{3'd4, 1, 1, 0, 4'd2};
        for (int i = 8; i < 12; i++) begin
            vec[i].rodadas = 3'($urandom_range(0, 7));
            vec[i].kind    = int'($urandom_range(0, 2));
            vec[i].ev_r    = int'($urandom_range(1, clamp_len(vec[i].rodadas)));
            vec[i].ev_j    = int'($urandom_range(0, vec[i].ev_r - 1));
            vec[i].key     = 4'($urandom_range(1, 15));
            if (vec[i].key == seq[vec[i].ev_j]) vec[i].key = vec[i].key ^ 4'hF;
        end

        for (int i = 0; i < 12; i++) begin
            play_game(vec[i], $sformatf("game_%0d", i));
        end

        // Exact timeout: ESPERA lasts TC cycles, then FIM_TIMEOUT.
        start_game(3'd1);
        wait_state(4'h3, "tmo_enter", ok);
        repeat (TC - 1) tick();
        check("tmo_last_espera_cycle", 32'(db_estado), 32'h3);
        tick();
        check("tmo_state", 32'(db_estado), 32'hF);
        check("tmo_flags", 32'({pronto, acertou, errou, timeout}), 32'b1001);

        // Play on the expiry cycle wins over timeout; check play latency.
        start_game(3'd1);
        wait_state(4'h3, "expiry_enter", ok);
        repeat (TC - 1) tick();
        chaves = 4'd1;
        tick();
        check("expiry_play_registra", 32'(db_estado), 32'h4);
        tick();
        check("latency_compara", 32'(db_estado), 32'h5);
        check("leds_latched", 32'(leds), 32'd1);
        tick();
        chaves = '0;
        wait_pronto("expiry_end", ok);
        check("expiry_win", 32'({pronto, acertou, errou, timeout}), 32'b1100);

        // iniciar and mem_we while playing are ignored.
        start_game(3'd1);
        wait_state(4'h3, "ignore_enter", ok);
        mem_we   = 1'b1;
        mem_addr = '0;
        mem_dado = 4'd8;
        iniciar  = 1'b1;
        tick();
        mem_we  = 1'b0;
        iniciar = 1'b0;
        check("iniciar_ignored", 32'(db_estado), 32'h3);
        check("iniciar_ignored_rodada", 32'(db_rodada), 32'd1);
        press(4'd1);
        wait_pronto("mem_we_end", ok);
        check("mem_unchanged_win", 32'({pronto, acertou, errou, timeout}), 32'b1100);

        // Key held into round 2 must not register; then reset mid-game.
        start_game(3'd2);
        wait_state(4'h3, "held_enter", ok);
        chaves = 4'd1;
        tick();
        wait_state(4'h3, "held_round2", ok);
        repeat (3) tick();
        check("held_no_play", 32'({db_estado, db_rodada, db_jogada, leds}), 32'({4'h3, 3'd2, 3'd0, 4'd1}));
        chaves = '0;
        tick();
        reset = 1'b0;
        tick();
        check("midgame_reset", 32'(out_word()), 32'd0);
        reset = 1'b1;
        tick();
        s = '{3'd2, 0, 0, 0, 4'd0};
        play_game(s, "after_reset_game");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
